// File: rtl/m3_commutation_scheduler.sv
// m3_commutation_scheduler
//
// Three-phase motor commutation sequencer. Turns operator controls into a
// 12-step commutation index with a one-cycle step strobe and an applied power
// level. Owns the step period, the power setpoint, direction reversal with a
// dead time, and the idle/run transitions.
//
// Ports:
//   clkI           clock, rising edge
//   nRstI          asynchronous active-low reset
//   m3startI       run enable (level)
//   m3forceStopI   emergency stop (level, highest priority)
//   m3invRotateI   requested direction, 0 = forward, 1 = reverse (level)
//   m3freqINCi     speed up, acted on at the 0->1 edge
//   m3freqDECi     speed down, acted on at the 0->1 edge
//   m3powerINCi    power up, acted on at the 0->1 edge
//   m3powerDECi    power down, acted on at the 0->1 edge
//   m3stepO        commutation index 0..11, 4'hF when not running
//   m3stepStrobeO  one-cycle pulse when m3stepO takes a new value in RUN
//   m3powerO       applied power level
//   m3runningO     high in RUN and REV
//   m3dirO         direction currently applied
//   m3revO         high during the reversal dead time
//
// Optional feature:
//   M3_SOFT_START_EN  when defined, applied power ramps up from 0 on every
//                     entry to RUN, by up to POWER_STEP per step strobe.

module m3_commutation_scheduler #(
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned PERIOD_START = 1000,
    parameter int unsigned PERIOD_MIN   = 100,
    parameter int unsigned PERIOD_MAX   = 4000,
    parameter int unsigned PERIOD_STEP  = 50,
    parameter int unsigned POWER_W      = 8,
    parameter int unsigned POWER_INIT   = 32,
    parameter int unsigned POWER_STEP   = 8,
    parameter int unsigned POWER_MAX    = 255,
    parameter int unsigned DEAD_CYC     = 16
) (
    input  logic               clkI,
    input  logic               nRstI,
    input  logic               m3startI,
    input  logic               m3forceStopI,
    input  logic               m3invRotateI,
    input  logic               m3freqINCi,
    input  logic               m3freqDECi,
    input  logic               m3powerINCi,
    input  logic               m3powerDECi,
    output logic [3:0]         m3stepO,
    output logic               m3stepStrobeO,
    output logic [POWER_W-1:0] m3powerO,
    output logic               m3runningO,
    output logic               m3dirO,
    output logic               m3revO
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REV
    } state_t;

    localparam int unsigned DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [3:0]  STEP_IDLE = 4'hF;
    localparam logic [3:0]  STEP_LAST = 4'd11;

    state_t              state, state_nx;
    logic [PERIOD_W-1:0] period, period_nx, period_evt;
    logic [PERIOD_W-1:0] cnt, cnt_nx;
    logic [POWER_W-1:0]  setpoint, setpoint_nx, power_nx;
    logic [DEAD_W-1:0]   dead, dead_nx;
    logic [3:0]          step_nx, step_adv;
    logic                strobe_nx, running_nx, dir_nx, rev_nx;

    // Bit order: {powerDEC, powerINC, freqDEC, freqINC}
    logic [3:0]          in_q, in_hist, in_edge;
    logic                freq_inc, freq_dec, pow_inc, pow_dec;

    logic [PERIOD_W:0]   period_sub, period_add;
    logic [POWER_W:0]    setpoint_sub, setpoint_add;
    logic                step_due;

`ifdef M3_SOFT_START_EN
    logic                ramping, ramping_nx;
    logic [POWER_W-1:0]  ramp_gap;
`endif

    // ------------------------------------------------------------------
    // Edge detection: inputs are registered once, then compared with the
    // previous sample, so an edge acts one cycle after it is sampled.
    // ------------------------------------------------------------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            in_q    <= '0;
            in_hist <= '0;
        end else begin
            in_q    <= {m3powerDECi, m3powerINCi, m3freqDECi, m3freqINCi};
            in_hist <= in_q;
        end
    end

    always_comb begin
        in_edge  = in_q & ~in_hist;
        // Simultaneous INC and DEC of the same pair cancel out.
        freq_inc = in_edge[0] & ~in_edge[1];
        freq_dec = in_edge[1] & ~in_edge[0];
        pow_inc  = in_edge[2] & ~in_edge[3];
        pow_dec  = in_edge[3] & ~in_edge[2];
    end

    // ------------------------------------------------------------------
    // Saturating period and setpoint arithmetic, one bit wider so that a
    // borrow or carry is visible before clamping.
    // ------------------------------------------------------------------
    always_comb begin
        period_sub = {1'b0, period} - (PERIOD_W+1)'(PERIOD_STEP);
        period_add = {1'b0, period} + (PERIOD_W+1)'(PERIOD_STEP);
        period_evt = period;
        if (freq_inc) begin
            if (period_sub[PERIOD_W] || (period_sub < (PERIOD_W+1)'(PERIOD_MIN)))
                period_evt = PERIOD_W'(PERIOD_MIN);
            else
                period_evt = period_sub[PERIOD_W-1:0];
        end else if (freq_dec) begin
            if (period_add > (PERIOD_W+1)'(PERIOD_MAX))
                period_evt = PERIOD_W'(PERIOD_MAX);
            else
                period_evt = period_add[PERIOD_W-1:0];
        end

        setpoint_sub = {1'b0, setpoint} - (POWER_W+1)'(POWER_STEP);
        setpoint_add = {1'b0, setpoint} + (POWER_W+1)'(POWER_STEP);
        setpoint_nx  = setpoint;
        if (pow_inc) begin
            if (setpoint_add > (POWER_W+1)'(POWER_MAX))
                setpoint_nx = POWER_W'(POWER_MAX);
            else
                setpoint_nx = setpoint_add[POWER_W-1:0];
        end else if (pow_dec) begin
            if (setpoint_sub[POWER_W])
                setpoint_nx = '0;
            else
                setpoint_nx = setpoint_sub[POWER_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Step timing. The ">=" compare (written as cnt+1 >= period) lets a
    // shortened period take effect on the next cycle without missing a step.
    // ------------------------------------------------------------------
    always_comb begin
        step_due = (({1'b0, cnt} + 1'b1) >= {1'b0, period});
        if (m3dirO) begin
            step_adv = (m3stepO == 4'd0) ? STEP_LAST : (m3stepO - 4'd1);
        end else begin
            step_adv = (m3stepO == STEP_LAST) ? 4'd0 : (m3stepO + 4'd1);
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state         <= ST_IDLE;
            period        <= PERIOD_W'(PERIOD_START);
            cnt           <= '0;
            setpoint      <= POWER_W'(POWER_INIT);
            dead          <= '0;
            m3stepO       <= STEP_IDLE;
            m3stepStrobeO <= 1'b0;
            m3powerO      <= '0;
            m3runningO    <= 1'b0;
            m3dirO        <= 1'b0;
            m3revO        <= 1'b0;
        end else begin
            state         <= state_nx;
            period        <= period_nx;
            cnt           <= cnt_nx;
            setpoint      <= setpoint_nx;
            dead          <= dead_nx;
            m3stepO       <= step_nx;
            m3stepStrobeO <= strobe_nx;
            m3powerO      <= power_nx;
            m3runningO    <= running_nx;
            m3dirO        <= dir_nx;
            m3revO        <= rev_nx;
        end
    end

`ifdef M3_SOFT_START_EN
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            ramping <= 1'b0;
        end else begin
            ramping <= ramping_nx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        step_nx    = m3stepO;
        strobe_nx  = 1'b0;
        power_nx   = m3powerO;
        running_nx = m3runningO;
        dir_nx     = m3dirO;
        rev_nx     = m3revO;
        cnt_nx     = cnt;
        dead_nx    = dead;
        // Force-stop suppresses frequency events; setpoint events always apply.
        period_nx  = m3forceStopI ? period : period_evt;
`ifdef M3_SOFT_START_EN
        ramping_nx = ramping;
        ramp_gap   = setpoint - m3powerO;
`endif

        case (state)
            ST_IDLE: begin
                step_nx    = STEP_IDLE;
                power_nx   = '0;
                running_nx = 1'b0;
                rev_nx     = 1'b0;
                if (m3startI && !m3forceStopI) begin
                    state_nx   = ST_RUN;
                    dir_nx     = m3invRotateI;
                    step_nx    = 4'd0;
                    strobe_nx  = 1'b1;
                    running_nx = 1'b1;
                    period_nx  = PERIOD_W'(PERIOD_START);
                    cnt_nx     = '0;
`ifdef M3_SOFT_START_EN
                    power_nx   = '0;
                    ramping_nx = 1'b1;
`else
                    power_nx   = setpoint;
`endif
                end
            end

            ST_RUN: begin
                if (m3forceStopI || !m3startI) begin
                    state_nx   = ST_IDLE;
                    step_nx    = STEP_IDLE;
                    power_nx   = '0;
                    running_nx = 1'b0;
                    rev_nx     = 1'b0;
                end else if (m3invRotateI != m3dirO) begin
                    // Reversal takes precedence over a same-cycle step advance.
                    state_nx = ST_REV;
                    rev_nx   = 1'b1;
                    power_nx = '0;
                    dead_nx  = '0;
                end else begin
                    if (step_due) begin
                        cnt_nx    = '0;
                        step_nx   = step_adv;
                        strobe_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
`ifdef M3_SOFT_START_EN
                    if (!ramping) begin
                        power_nx = setpoint;
                    end else if (setpoint <= m3powerO) begin
                        power_nx   = setpoint;
                        ramping_nx = 1'b0;
                    end else if (step_due) begin
                        if (ramp_gap <= POWER_W'(POWER_STEP)) begin
                            power_nx   = setpoint;
                            ramping_nx = 1'b0;
                        end else begin
                            power_nx = m3powerO + POWER_W'(POWER_STEP);
                        end
                    end
`else
                    power_nx = setpoint;
`endif
                end
            end

            ST_REV: begin
                if (m3forceStopI || !m3startI) begin
                    state_nx   = ST_IDLE;
                    step_nx    = STEP_IDLE;
                    power_nx   = '0;
                    running_nx = 1'b0;
                    rev_nx     = 1'b0;
                end else if (dead == DEAD_W'(DEAD_CYC - 1)) begin
                    // Direction is sampled only at the end of the dead time.
                    state_nx  = ST_RUN;
                    rev_nx    = 1'b0;
                    dir_nx    = m3invRotateI;
                    period_nx = PERIOD_W'(PERIOD_START);
                    cnt_nx    = '0;
`ifdef M3_SOFT_START_EN
                    power_nx   = '0;
                    ramping_nx = 1'b1;
`else
                    power_nx   = setpoint;
`endif
                end else begin
                    dead_nx  = dead + 1'b1;
                    power_nx = '0;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m3_commutation_scheduler.sv
// tb_m3_commutation_scheduler
//
// Self-checking bench for m3_commutation_scheduler. Expected values come from
// arithmetic on the operating rules: step index = f(cycles since start,
// period, direction), saturating setpoint/period models updated per pulse.
// Built with PERIOD_START=8 and DEAD_CYC=16. The soft-start ramp check is
// compiled in when M3_SOFT_START_EN is defined.

module tb_m3_commutation_scheduler;

    localparam int unsigned P_START = 8;
    localparam int unsigned DEAD    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       force_stop = 1'b0;
    logic       inv = 1'b0;
    logic       f_inc = 1'b0;
    logic       f_dec = 1'b0;
    logic       p_inc = 1'b0;
    logic       p_dec = 1'b0;
    logic [3:0] step;
    logic       strobe;
    logic [7:0] power;
    logic       running;
    logic       dir;
    logic       rev;

    int total = 0;
    int bad = 0;
    int sp_model = 32;
    int per_model = P_START;

    always #5 clk = ~clk;

    m3_commutation_scheduler #(
        .PERIOD_W    (16),
        .PERIOD_START(P_START),
        .PERIOD_MIN  (100),
        .PERIOD_MAX  (4000),
        .PERIOD_STEP (50),
        .POWER_W     (8),
        .POWER_INIT  (32),
        .POWER_STEP  (8),
        .POWER_MAX   (255),
        .DEAD_CYC    (DEAD)
    ) dut (
        .clkI         (clk),
        .nRstI        (rst_n),
        .m3startI     (start),
        .m3forceStopI (force_stop),
        .m3invRotateI (inv),
        .m3freqINCi   (f_inc),
        .m3freqDECi   (f_dec),
        .m3powerINCi  (p_inc),
        .m3powerDECi  (p_dec),
        .m3stepO      (step),
        .m3stepStrobeO(strobe),
        .m3powerO     (power),
        .m3runningO   (running),
        .m3dirO       (dir),
        .m3revO       (rev)
    );

    // Advance one clock; inputs change and outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // op: 0 = INC, 1 = DEC, 2 = both in the same cycle
    task automatic pulse_power(input int op);
        p_inc = (op != 1);
        p_dec = (op != 0);
        cyc();
        p_inc = 1'b0;
        p_dec = 1'b0;
        cyc();
        cyc();
        if (op == 0)      sp_model = (sp_model + 8 > 255) ? 255 : sp_model + 8;
        else if (op == 1) sp_model = (sp_model < 8) ? 0 : sp_model - 8;
    endtask

    task automatic pulse_freq(input bit up);
        f_inc = up;
        f_dec = !up;
        cyc();
        f_inc = 1'b0;
        f_dec = 1'b0;
        cyc();
        cyc();
        if (up) per_model = (per_model - 50 < 100) ? 100 : per_model - 50;
        else    per_model = (per_model + 50 > 4000) ? 4000 : per_model + 50;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        if ({step, strobe, power, running, dir, rev} !== {4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs got=%h/%b/%0d/%b/%b/%b exp=f/0/0/0/0/0", step, strobe, power, running, dir, rev);
            bad++;
        end
        total++;
        rst_n = 1'b1;
        cyc();
        if ({step, running} !== {4'hF, 1'b0}) begin
            $display("FAIL reset_idle got step=%h run=%b exp step=f run=0", step, running);
            bad++;
        end
        total++;
    endtask

    task automatic test_forward();
        logic [3:0] es;
        logic       est;
        inv = 1'b0;
        start = 1'b1;
        cyc();
        for (int k = 0; k <= 13 * P_START; k++) begin
            if (k > 0) cyc();
            es  = 4'((k / P_START) % 12);
            est = ((k % P_START) == 0);
            if ({step, strobe, running, dir, power} !== {es, est, 1'b1, 1'b0, 8'(sp_model)}) begin
                $display("FAIL fwd k=%0d got step=%0d stb=%b run=%b dir=%b pwr=%0d exp step=%0d stb=%b pwr=%0d",
                         k, step, strobe, running, dir, power, es, est, sp_model);
                bad++;
            end
            total++;
        end
        start = 1'b0;
        cyc();
        if ({step, strobe, power, running} !== {4'hF, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL fwd_stop got step=%h pwr=%0d run=%b exp step=f pwr=0 run=0", step, power, running);
            bad++;
        end
        total++;
    endtask

    task automatic test_reverse_run();
        logic [3:0] es;
        logic       est;
        int         len;
        len = $urandom_range(20, 60);
        inv = 1'b1;
        start = 1'b1;
        cyc();
        for (int k = 0; k <= len; k++) begin
            if (k > 0) cyc();
            es  = 4'((12 - (k / P_START) % 12) % 12);
            est = ((k % P_START) == 0);
            if ({step, strobe, dir} !== {es, est, 1'b1}) begin
                $display("FAIL rev_run k=%0d got step=%0d stb=%b dir=%b exp step=%0d stb=%b dir=1",
                         k, step, strobe, dir, es, est);
                bad++;
            end
            total++;
        end
        start = 1'b0;
        cyc();
        if ({step, power, running} !== {4'hF, 8'd0, 1'b0}) begin
            $display("FAIL rev_run_stop got step=%h pwr=%0d run=%b exp step=f pwr=0 run=0", step, power, running);
            bad++;
        end
        total++;
        inv = 1'b0;
    endtask

    task automatic test_power();
        int op;
        inv = 1'b0;
        start = 1'b1;
        cyc();
        pulse_power(2);
        if (power !== 8'(sp_model)) begin
            $display("FAIL pwr_both got=%0d exp=%0d", power, sp_model);
            bad++;
        end
        total++;
        for (int i = 0; i < 40; i++) begin
            pulse_power(0);
            if (power !== 8'(sp_model)) begin
                $display("FAIL pwr_inc i=%0d got=%0d exp=%0d", i, power, sp_model);
                bad++;
            end
            total++;
        end
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 2);
            pulse_power(op);
            if (power !== 8'(sp_model)) begin
                $display("FAIL pwr_rand i=%0d op=%0d got=%0d exp=%0d", i, op, power, sp_model);
                bad++;
            end
            total++;
        end
        for (int i = 0; i < 40; i++) begin
            pulse_power(1);
            if (power !== 8'(sp_model)) begin
                $display("FAIL pwr_dec i=%0d got=%0d exp=%0d", i, power, sp_model);
                bad++;
            end
            total++;
        end
        for (int i = 0; i < 5; i++) pulse_power(0);
        if (power !== 8'(sp_model)) begin
            $display("FAIL pwr_final got=%0d exp=%0d", power, sp_model);
            bad++;
        end
        total++;
        start = 1'b0;
        cyc();
    endtask

    task automatic test_freq();
        int n;
        int gap;
        bit found;
        start = 1'b1;
        inv = 1'b0;
        cyc();
        for (int stage = 0; stage < 3; stage++) begin
            n = (stage == 1) ? $urandom_range(5, 20) : 100;
            for (int i = 0; i < n; i++) pulse_freq(stage != 0);
            found = 1'b0;
            for (int c = 0; c < 9000; c++) begin
                if (strobe) begin
                    found = 1'b1;
                    break;
                end
                cyc();
            end
            gap = 0;
            if (found) begin
                cyc();
                gap = 1;
                while (!strobe && gap < 9000) begin
                    cyc();
                    gap++;
                end
            end
            if (gap != per_model) begin
                $display("FAIL freq_spacing stage=%0d got=%0d exp=%0d", stage, gap, per_model);
                bad++;
            end
            total++;
        end
        start = 1'b0;
        cyc();
    endtask

    task automatic test_reversal();
        int r;
        int t;
        logic [3:0] held;
        logic [3:0] held2;
        inv = 1'b0;
        start = 1'b1;
        cyc();
        r = $urandom_range(10, 40);
        if (r % P_START == 0) r++;
        for (int k = 1; k < r; k++) cyc();
        held = 4'(((r - 1) / P_START) % 12);
        if (step !== held) begin
            $display("FAIL revsl_pre got=%0d exp=%0d", step, held);
            bad++;
        end
        total++;
        inv = 1'b1;
        cyc();
        for (int j = 0; j < DEAD; j++) begin
            if (j > 0) cyc();
            if ({rev, power, step, strobe, running} !== {1'b1, 8'd0, held, 1'b0, 1'b1}) begin
                $display("FAIL revsl_dead j=%0d got rev=%b pwr=%0d step=%0d stb=%b run=%b exp rev=1 pwr=0 step=%0d stb=0 run=1",
                         j, rev, power, step, strobe, running, held);
                bad++;
            end
            total++;
        end
        cyc();
        if ({rev, dir, step, strobe, power, running} !== {1'b0, 1'b1, held, 1'b0, 8'(sp_model), 1'b1}) begin
            $display("FAIL revsl_exit got rev=%b dir=%b step=%0d stb=%b pwr=%0d exp rev=0 dir=1 step=%0d stb=0 pwr=%0d",
                     rev, dir, step, strobe, power, held, sp_model);
            bad++;
        end
        total++;
        held2 = 4'((held + 11) % 12);
        for (int j = DEAD + 1; j <= DEAD + P_START; j++) begin
            cyc();
            if ({strobe, step} !== {(j == DEAD + P_START), ((j == DEAD + P_START) ? held2 : held)}) begin
                $display("FAIL revsl_first j=%0d got stb=%b step=%0d exp stb=%b", j, strobe, step, (j == DEAD + P_START));
                bad++;
            end
            total++;
        end
        // Request forward, then flip back mid dead time: dead time still runs out.
        inv = 1'b0;
        cyc();
        t = $urandom_range(2, 10);
        for (int j = 0; j < DEAD; j++) begin
            if (j > 0) cyc();
            if ({rev, step} !== {1'b1, held2}) begin
                $display("FAIL revsl_back j=%0d got rev=%b step=%0d exp rev=1 step=%0d", j, rev, step, held2);
                bad++;
            end
            total++;
            if (j == t) inv = 1'b1;
        end
        cyc();
        if ({rev, dir, step, power} !== {1'b0, 1'b1, held2, 8'(sp_model)}) begin
            $display("FAIL revsl_back_exit got rev=%b dir=%b step=%0d pwr=%0d exp rev=0 dir=1 step=%0d pwr=%0d",
                     rev, dir, step, power, held2, sp_model);
            bad++;
        end
        total++;
        start = 1'b0;
        cyc();
        if ({step, running, rev} !== {4'hF, 1'b0, 1'b0}) begin
            $display("FAIL revsl_stop got step=%h run=%b rev=%b exp f/0/0", step, running, rev);
            bad++;
        end
        total++;
        inv = 1'b0;
    endtask

    task automatic test_force_stop();
        int exp_p;
        bit found;
        inv = 1'b0;
        start = 1'b1;
        force_stop = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            if ({step, running, strobe} !== {4'hF, 1'b0, 1'b0}) begin
                $display("FAIL fstop_hold j=%0d got step=%h run=%b exp step=f run=0", j, step, running);
                bad++;
            end
            total++;
        end
        for (int i = 0; i < 4; i++) pulse_power(0);
        if ({step, running} !== {4'hF, 1'b0}) begin
            $display("FAIL fstop_hold_pwr got step=%h run=%b exp step=f run=0", step, running);
            bad++;
        end
        total++;
        force_stop = 1'b0;
        cyc();
        if ({step, strobe, running} !== {4'd0, 1'b1, 1'b1}) begin
            $display("FAIL fstop_release got step=%h stb=%b run=%b exp 0/1/1", step, strobe, running);
            bad++;
        end
        total++;
`ifdef M3_SOFT_START_EN
        if (power !== 8'd0) begin
            $display("FAIL soft_entry got=%0d exp=0", power);
            bad++;
        end
        total++;
        for (int i = 1; i <= 5; i++) begin
            found = 1'b0;
            for (int c = 0; c < 2 * P_START + 2; c++) begin
                cyc();
                if (strobe) begin
                    found = 1'b1;
                    break;
                end
            end
            exp_p = (8 * i < sp_model) ? 8 * i : sp_model;
            if (!found || power !== 8'(exp_p)) begin
                $display("FAIL soft_ramp i=%0d found=%b got=%0d exp=%0d", i, found, power, exp_p);
                bad++;
            end
            total++;
        end
`else
        exp_p = sp_model;
        found = 1'b1;
        if (power !== 8'(exp_p)) begin
            $display("FAIL fstop_power got=%0d exp=%0d", power, exp_p);
            bad++;
        end
        total++;
`endif
        repeat (3) cyc();
        force_stop = 1'b1;
        cyc();
        if ({step, strobe, power, running} !== {4'hF, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL fstop_run got step=%h stb=%b pwr=%0d run=%b exp f/0/0/0", step, strobe, power, running);
            bad++;
        end
        total++;
        force_stop = 1'b0;
        start = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        inv = 1'b1;
        start = 1'b1;
        cyc();
        repeat ($urandom_range(3, 20)) cyc();
        #2 rst_n = 1'b0;
        #1;
        if ({step, strobe, power, running, dir, rev} !== {4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL async_reset got=%h/%b/%0d/%b/%b/%b exp=f/0/0/0/0/0", step, strobe, power, running, dir, rev);
            bad++;
        end
        total++;
        start = 1'b0;
        inv = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        sp_model = 32;
        start = 1'b1;
        cyc();
`ifdef M3_SOFT_START_EN
        if ({step, strobe, running, power} !== {4'd0, 1'b1, 1'b1, 8'd0}) begin
`else
        if ({step, strobe, running, power} !== {4'd0, 1'b1, 1'b1, 8'(sp_model)}) begin
`endif
            $display("FAIL async_restart got step=%h stb=%b run=%b pwr=%0d", step, strobe, running, power);
            bad++;
        end
        total++;
        start = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse_run();
        test_power();
        test_freq();
        test_reversal();
        test_force_stop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m3_commutation_scheduler.md
# m3_commutation_scheduler

Sequencer for the three-phase motor drive. It turns the operator controls (start, force-stop, direction, frequency up/down, power up/down) into a 12-step commutation index, a one-cycle step strobe and a power level for the downstream phase-drive/PWM logic. It owns the step period, the power setpoint, direction reversal with dead time, and the idle/run transitions. It sits between the front-panel/debounce logic and the phase output stage.

## Interface
- `PERIOD_W`, 16, width of the step-period counter and register
- `PERIOD_START`, 1000, step period in clocks loaded at reset and on every entry to RUN
- `PERIOD_MIN`, 100, minimum period (fastest speed)
- `PERIOD_MAX`, 4000, maximum period (slowest speed)
- `PERIOD_STEP`, 50, period change per frequency INC/DEC event
- `POWER_W`, 8, power width
- `POWER_INIT`, 32, power setpoint after reset
- `POWER_STEP`, 8, setpoint change per power INC/DEC event
- `POWER_MAX`, 255, setpoint ceiling
- `DEAD_CYC`, 16, reversal dead time in clocks
- `clkI` in 1: clock, rising edge
- `nRstI` in 1: asynchronous, active-low reset
- `m3startI` in 1: run enable, level
- `m3forceStopI` in 1: emergency stop, level, highest priority
- `m3invRotateI` in 1: requested direction (0 = forward, 1 = reverse), level
- `m3freqINCi` / `m3freqDECi` in 1: speed up / down, acted on at the 0→1 edge
- `m3powerINCi` / `m3powerDECi` in 1: power up / down, acted on at the 0→1 edge
- `m3stepO` out 4: commutation index 0..11; 4'hF when not running
- `m3stepStrobeO` out 1: one-cycle pulse in the cycle `m3stepO` takes a new value in RUN
- `m3powerO` out POWER_W: applied power level
- `m3runningO` out 1: high in RUN and REV
- `m3dirO` out 1: direction currently applied
- `m3revO` out 1: high during reversal dead time

## Operation
- All outputs are registered. Reset values:
  - `m3stepO` = 4'hF.
  - `m3stepStrobeO`, `m3powerO`, `m3runningO`, `m3dirO` and `m3revO` = 0.
  - Period register = PERIOD_START.
  - Power setpoint = POWER_INIT.
  - Edge-detect history registers = 0.
  - State = IDLE.
- State IDLE:
  - Outputs: step F, power 0.
  - Transition: if `m3startI`=1 and `m3forceStopI`=0, go to RUN with dir ← `m3invRotateI`, step ← 0, strobe = 1, period ← PERIOD_START, period counter ← 0.
- State RUN:
  - Period counter increments each clock.
  - When counter ≥ period−1, the counter clears and the step advances:
    - dir = 0: +1, with 11→0.
    - dir = 1: −1, with 0→11.
    - Strobe = 1 in that cycle.
  - The `≥` compare makes a shortened period take effect without a missed step.
- Frequency events (in any state):
  - INC: period −= PERIOD_STEP, saturating at PERIOD_MIN.
  - DEC: period += PERIOD_STEP, saturating at PERIOD_MAX.
- Power events (in any state):
  - INC: setpoint += POWER_STEP, saturating at POWER_MAX.
  - DEC: setpoint −= POWER_STEP, saturating at 0.
  - Arithmetic is done one bit wider before clamping.
- Simultaneous INC and DEC edges of the same pair in one cycle: no change.
- Reversal request, RUN → REV: in RUN, when `m3invRotateI` ≠ dir.
- State REV:
  - `m3revO` = 1, power forced to 0, step held, no strobes.
  - After DEAD_CYC clocks: dir ← `m3invRotateI` (sampled then), period ← PERIOD_START, counter ← 0, return to RUN without a strobe.
  - If the input toggles back during REV, the dead time still completes.
- `m3startI`=0 in RUN or REV → IDLE next cycle.
- `m3forceStopI`=1 in any state → IDLE next cycle. It overrides all same-cycle events except setpoint updates, and blocks a start while held.
- Power in RUN: without soft start, `m3powerO` = setpoint (tracking changes next cycle).

## Timing
- Start sampled high at edge N → `m3stepO`=0, `m3stepStrobeO`=1, `m3runningO`=1 after edge N.
- The first advance is PERIOD_START clocks later; afterwards one step every period clocks.
- An input edge sampled at edge N updates the setpoint/period after edge N+1 (one cycle of edge-detect latency).
- Force-stop or start-low sampled at edge N → IDLE outputs after edge N.
- An asynchronous reset mid-step returns the block to the reset values immediately.

## Configuration
- `M3_SOFT_START_EN` defined:
  - On each entry to RUN, from IDLE or from REV, `m3powerO` starts at 0.
  - It rises by min(POWER_STEP, setpoint − output) on each step strobe until it equals the setpoint, then tracks the setpoint.
  - A setpoint decrease below the current output applies immediately.
- `M3_SOFT_START_EN` undefined: `m3powerO` = setpoint throughout RUN.

## Test plan
- Reset, then start=1, dir=0 with PERIOD_START=8 → step 0,1,…,11,0 with a strobe every 8 clocks; the step after 11 is 0.
- dir=1 start → step 0,11,10,…; drop start mid-run → step=F, power=0 next cycle.
- 20 freqINC pulses from period 1000 → period clamps at 100, step spacing 100 clocks; 100 freqDEC pulses → clamps at 4000.
- powerINC and powerDEC edges in the same cycle → setpoint unchanged at 32; 40 INC pulses → 255.
- Toggle `m3invRotateI` in RUN with DEAD_CYC=16 → rev=1 and power=0 for 16 clocks, step frozen, then dir flips and the first strobe comes 8 clocks later (PERIOD_START=8).
- Hold forceStop with start=1 → stays IDLE; release → RUN next cycle. With `M3_SOFT_START_EN`, power ramps 0,8,16,24,32 on successive strobes.
